// File: rtl/efuse_wb_loader.sv
// efuse_wb_loader: Wishbone classic read initiator that copies the user eFuse
// block into a local shadow register file after reset or on request.
// Optional build macro EFUSE_LOADER_CRC_EN adds a CRC-8 integrity check over
// the shadowed bytes; without it crc_ok_o is tied high.
module efuse_wb_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int unsigned NUM_WORDS   = 64,
  parameter int unsigned ADDR_STRIDE = 4,
  parameter int unsigned TIMEOUT     = 255,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [7:0]  err_idx_o,
  input  logic [7:0]  shadow_idx_i,
  output logic [7:0]  shadow_data_o,
  output logic        crc_ok_o
);

  localparam int unsigned    IW       = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_WORDS - 1);
  localparam logic [9:0]     TO_LAST  = 10'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_GAP,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_auto;
  logic [IW-1:0] r_idx;
  logic [9:0]    r_cnt;
  logic [7:0]    r_err_idx;
  logic [7:0]    r_shadow [NUM_WORDS];

  logic          w_load;
  logic          w_capture;
  logic          w_fail;
  logic          w_advance;
  logic          w_unused_dat;

  assign w_unused_dat = ^wbm_dat_i[31:8];

  // Next-state decode and datapath control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_capture   = 1'b0;
    w_fail      = 1'b0;
    w_advance   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_auto || start_i) begin
          w_state_nxt = S_REQ;
          w_load      = 1'b1;
        end
      end
      S_REQ: begin
        // err has priority over a simultaneous ack: nothing is captured
        if (wbm_err_i) begin
          w_state_nxt = S_ERROR;
          w_fail      = 1'b1;
        end else if (wbm_ack_i) begin
          w_state_nxt = S_GAP;
          w_capture   = 1'b1;
        end else if (r_cnt >= TO_LAST) begin
          w_state_nxt = S_ERROR;
          w_fail      = 1'b1;
        end
      end
      S_GAP: begin
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_REQ;
          w_advance   = 1'b1;
        end
      end
      S_DONE, S_ERROR: begin
        if (start_i) begin
          w_state_nxt = S_REQ;
          w_load      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, word index, timeout counter and error index
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state   <= S_IDLE;
      r_auto    <= AUTO_START;
      r_idx     <= '0;
      r_cnt     <= '0;
      r_err_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_auto <= 1'b0;
        r_idx  <= '0;
        r_cnt  <= '0;
      end else if (w_advance) begin
        r_idx <= r_idx + 1'b1;
        r_cnt <= '0;
      end else if (r_state == S_REQ && r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_fail) begin
        r_err_idx <= 8'(r_idx);
      end
    end
  end

  // Shadow register file: cleared by reset, one byte written per good ack
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        r_shadow[i] <= '0;
      end
    end else if (w_capture) begin
      r_shadow[r_idx] <= wbm_dat_i[7:0];
    end
  end

  assign wbm_cyc_o = (r_state == S_REQ);
  assign wbm_stb_o = (r_state == S_REQ);
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = wbm_cyc_o ? 4'b0001 : 4'b0000;
  assign wbm_adr_o = wbm_cyc_o ? (BASE_ADDR + (32'(r_idx) * 32'(ADDR_STRIDE))) : '0;
  assign wbm_dat_o = '0;

  assign busy_o    = (r_state == S_REQ) || (r_state == S_GAP);
  assign done_o    = (r_state == S_DONE);
  assign err_o     = (r_state == S_ERROR);
  assign err_idx_o = r_err_idx;

  // Asynchronous shadow read port, zero outside the populated range
  always_comb begin
    shadow_data_o = '0;
    if (32'(shadow_idx_i) < NUM_WORDS) begin
      shadow_data_o = r_shadow[shadow_idx_i[IW-1:0]];
    end
  end

`ifdef EFUSE_LOADER_CRC_EN
  logic [7:0] r_crc;

  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned b = 0; b < 8; b++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

  // Running CRC-8 over every captured byte except the last, which holds the reference
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_crc <= '0;
    end else if (w_load) begin
      r_crc <= '0;
    end else if (w_capture && r_idx != LAST_IDX) begin
      r_crc <= crc8_next(r_crc, wbm_dat_i[7:0]);
    end
  end

  assign crc_ok_o = (r_state == S_DONE) && (r_crc == r_shadow[LAST_IDX]);
`else
  assign crc_ok_o = 1'b1;
`endif

endmodule
